// File: rtl/race_controller.sv
// Race sequencer: starts enabled observer lanes, collects their dones, reports winner/tie/timing.
// Optional run-phase timeout is compiled in with `define RACE_TIMEOUT_EN.
module race_controller #(
  parameter int unsigned N_LANES        = 4,
  parameter int unsigned LW             = $clog2(N_LANES),
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [N_LANES-1:0] lane_en,
  input  logic [N_LANES-1:0] lane_done,
  output logic [N_LANES-1:0] lane_start,
  output logic               busy,
  output logic               result_valid,
  output logic [LW-1:0]      winner,
  output logic               tie,
  output logic [N_LANES-1:0] finish_mask,
  output logic [15:0]        race_cycles,
  output logic               timeout
);

  if (N_LANES < 2 || N_LANES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : gen_param_check
    $error("race_controller: parameter out of range");
  end

  localparam logic [N_LANES-1:0] LaneOne = {{(N_LANES-1){1'b0}}, 1'b1};

  // 3-bit encoding leaves spare codes that recover to IDLE.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StRelease = 3'd2,
    StReport  = 3'd3
  } state_e;

  state_e             state_q, state_d;
  logic [N_LANES-1:0] en_q, en_d;
  logic [N_LANES-1:0] start_q, start_d;
  logic [N_LANES-1:0] finish_q, finish_d;
  logic [LW-1:0]      winner_q, winner_d;
  logic               tie_q, tie_d;
  logic               found_q, found_d;
  logic [15:0]        cyc_q, cyc_d;
  logic [15:0]        race_cycles_q, race_cycles_d;
`ifdef RACE_TIMEOUT_EN
  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES - 1);
  logic               timeout_q, timeout_d;
`endif

  logic [N_LANES-1:0] hits;
  logic               all_done;
  logic               multi_hit;
  logic [LW-1:0]      first_idx;
  logic               accept;
  logic [15:0]        cyc_inc;

  assign hits      = lane_done & en_q;
  assign all_done  = ((finish_q | hits) == en_q);
  assign multi_hit = |(hits & (hits - LaneOne));
  assign accept    = go && (lane_en != '0) && ((lane_done & lane_en) == '0);
  assign cyc_inc   = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

  always_comb begin
    first_idx = '0;
    for (int i = int'(N_LANES) - 1; i >= 0; i--) begin
      if (hits[i]) first_idx = LW'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    start_d       = start_q;
    finish_d      = finish_q;
    winner_d      = winner_q;
    tie_d         = tie_q;
    found_d       = found_q;
    cyc_d         = cyc_q;
    race_cycles_d = race_cycles_q;
`ifdef RACE_TIMEOUT_EN
    timeout_d     = timeout_q;
`endif

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d       = StRun;
          en_d          = lane_en;
          start_d       = lane_en;
          finish_d      = '0;
          winner_d      = '0;
          tie_d         = 1'b0;
          found_d       = 1'b0;
          cyc_d         = '0;
          race_cycles_d = '0;
`ifdef RACE_TIMEOUT_EN
          timeout_d     = 1'b0;
`endif
        end
      end

      StRun: begin
        finish_d = finish_q | hits;
        cyc_d    = cyc_inc;
        if (!found_q && (hits != '0)) begin
          found_d       = 1'b1;
          winner_d      = first_idx;
          tie_d         = multi_hit;
          race_cycles_d = cyc_q;
        end
        if (all_done) begin
          state_d = StRelease;
          start_d = '0;
        end
`ifdef RACE_TIMEOUT_EN
        else if (cyc_q >= TimeoutLim) begin
          state_d   = StRelease;
          start_d   = '0;
          timeout_d = 1'b1;
          if (!found_q && (hits == '0)) begin
            winner_d      = '0;
            tie_d         = 1'b0;
            race_cycles_d = 16'hFFFF;
          end
        end
`endif
      end

      StRelease: begin
        start_d = '0;
        if (hits == '0) state_d = StReport;
      end

      StReport: begin
        state_d = StIdle;
      end

      default: begin
        state_d       = StIdle;
        en_d          = '0;
        start_d       = '0;
        finish_d      = '0;
        winner_d      = '0;
        tie_d         = 1'b0;
        found_d       = 1'b0;
        cyc_d         = '0;
        race_cycles_d = '0;
`ifdef RACE_TIMEOUT_EN
        timeout_d     = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      en_q          <= '0;
      start_q       <= '0;
      finish_q      <= '0;
      winner_q      <= '0;
      tie_q         <= 1'b0;
      found_q       <= 1'b0;
      cyc_q         <= '0;
      race_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      start_q       <= start_d;
      finish_q      <= finish_d;
      winner_q      <= winner_d;
      tie_q         <= tie_d;
      found_q       <= found_d;
      cyc_q         <= cyc_d;
      race_cycles_q <= race_cycles_d;
    end
  end

`ifdef RACE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_d;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign lane_start   = start_q;
  assign busy         = (state_q != StIdle);
  assign result_valid = (state_q == StReport);
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign finish_mask  = finish_q;
  assign race_cycles  = race_cycles_q;

endmodule

// File: doc/race_controller.md
# race_controller

Sequencing controller for a bank of `N_LANES` race observers. It runs one race at a time by driving each lane's `start` with a 4-phase start/done handshake and collecting every lane's `done`. It records the winning lane, ties, the set of finishers and the elapsed cycles, then releases all lanes and reports one result. It sits between the top-level user control (`go`) and the observer array.

## Interface
Parameters:
- `N_LANES`, default 4: number of observer lanes, from 2 to 16.
- `LW`, default `$clog2(N_LANES)`: width of the winner index.
- `TIMEOUT_CYCLES`, default 1000: run-phase limit; used only with `RACE_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `go`  in  1  request to start a race; level-sampled in IDLE.
- `lane_en`  in  N_LANES  lanes that take part; captured when `go` is accepted.
- `lane_done`  in  N_LANES  `done` from each observer; synchronous to `clk`.
- `lane_start`  out  N_LANES  `start` to each observer, registered.
- `busy`  out  1  high in every state except IDLE.
- `result_valid`  out  1  one-cycle pulse in REPORT.
- `winner`  out  LW  index of the first finisher, lowest index on a tie.
- `tie`  out  1  more than one lane finished in the winning cycle.
- `finish_mask`  out  N_LANES  lanes whose `done` rose during this race.
- `race_cycles`  out  16  cycles from the first `lane_start` high to the first `done`; saturates at 16'hFFFF.
- `timeout`  out  1  the race ended by timeout; constant 0 without the macro.

## Operation
- Reset state: IDLE.
- Reset values:
  - `lane_start` = 0, `busy` = 0, `result_valid` = 0, `tie` = 0, `timeout` = 0.
  - `winner` = 0, `finish_mask` = 0, `race_cycles` = 0.
- `winner`, `tie`, `finish_mask`, `race_cycles` and `timeout` hold their values until the next race is accepted.
- States and transitions:
  - IDLE: accept `go` only when `go` = 1, `lane_en` ≠ 0 and `(lane_done & lane_en)` = 0. On accept:
    - latch `lane_en` into `en_q`;
    - clear `finish_mask`, `tie`, `timeout` and the cycle counter;
    - go to RUN and set `lane_start <= en_q`.
  - RUN:
    - `finish_mask |= lane_done & en_q` every cycle.
    - In the first cycle where any enabled `done` is high, latch `winner` = lowest set index and `tie` = (popcount > 1). Freeze `race_cycles`.
    - When `finish_mask | (lane_done & en_q)` equals `en_q`, go to RELEASE.
  - RELEASE: `lane_start` = 0. Wait until `(lane_done & en_q)` = 0, then go to REPORT.
  - REPORT: `result_valid` = 1 for one cycle, then go to IDLE.
- Disabled lanes never receive `start`, and their `done` is ignored throughout.
- A `done` that drops before `start` is released still counts; once a lane's bit is set in `finish_mask` it stays set.
- `go` held high re-arms a new race on the first IDLE cycle that meets the acceptance conditions. Back-to-back races cost a minimum of one IDLE cycle.
- Out-of-range or illegal state encodings go to IDLE with all outputs at their reset values.
- `rst` asserted mid-race immediately returns every output to its reset value, including `lane_start` = 0.

## Timing
- `go` accepted at edge k: `lane_start` is high after edge k, and `busy` goes high after edge k.
- `race_cycles` = number of RUN cycles before the cycle in which the first enabled `done` is sampled high. An observer answering on the first RUN cycle gives 0.
- Last enabled `done` sampled at edge m: `lane_start` goes low after edge m.
- All enabled `done` low sampled at edge r: `result_valid` is high for the cycle after edge r.
- Minimum race length from `go` accept to `result_valid` is 3 cycles: RUN, RELEASE, REPORT.

## Configuration
- `RACE_TIMEOUT_EN` defined:
  - a 16-bit run counter counts RUN cycles;
  - when it reaches `TIMEOUT_CYCLES` with enabled lanes still unfinished, set `timeout` = 1 and go to RELEASE;
  - `finish_mask` holds only the lanes that finished;
  - if no lane finished, `winner` = 0, `tie` = 0 and `race_cycles` = 16'hFFFF.
- `RACE_TIMEOUT_EN` undefined: RUN waits forever, and `timeout` is tied to 0.

## Test plan
- Single winner: `N_LANES` = 4, `lane_en` = 4'b1111, dones rise in the order lanes 2, 0, 3, 1, with lane 2 on RUN cycle 5 -> `winner` = 2, `tie` = 0, `race_cycles` = 5, `finish_mask` = 4'b1111, one `result_valid` pulse.
- Tie: lanes 1 and 3 raise `done` in the same cycle first -> `winner` = 1, `tie` = 1.
- Lane mask: `lane_en` = 4'b0101, with lane 1 `done` forced high -> `lane_start` = 4'b0101 only; lane 1 ignored; `finish_mask` = 4'b0101.
- Stale done: lane 0 `done` = 1 when `go` rises -> `busy` stays 0 until lane 0 `done` = 0, and the race starts on the next edge.
- Reset mid-RUN: assert `rst` while `lane_start` = 4'b1111 -> all outputs are 0 immediately, and the next `go` runs a clean race.
- Timeout (with macro): `TIMEOUT_CYCLES` = 20, lane 3 never finishes -> `timeout` = 1, `finish_mask` = 4'b0111, `result_valid` after release; without the macro, `busy` stays high past 20 cycles.
